// File: rtl/bin_a_bcd_barrido_if.sv
// bin_a_bcd_barrido_if: load strobe, status and scan outputs
// of the seven-segment display front-end.
interface bin_a_bcd_barrido_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] valor;
    logic             cargar;
    logic             ocupado;
    logic             listo;
    logic [3:0]       digito;
    logic [7:0]       anodo;

    modport master (
        output valor, cargar,
        input  ocupado, listo, digito, anodo
    );

    modport slave (
        input  valor, cargar,
        output ocupado, listo, digito, anodo
    );
endinterface

// File: rtl/bin_a_bcd_barrido.sv
// bin_a_bcd_barrido: binary capture, sequential double-dabble
// to packed BCD, and multiplexed digit/anode scanning.
module bin_a_bcd_barrido #(
    parameter int WIDTH       = 16,
    parameter int NDIG        = 5,
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input logic clk,
    input logic rst_n,
    bin_a_bcd_barrido_if.slave bus
);
    localparam int AW = 4 * NDIG;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    acc_add;
    logic [AW-1:0]    acc_d;
    logic [AW-1:0]    disp_q;
    logic [AW-1:0]    disp_d;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [CW-1:0]    cnt_q;
    logic             ocupado_q;
    logic             listo_q;

    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic             wrap;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic [2:0]       lead;
    logic [31:0]      disp_pad;
    logic [3:0]       digito_q;
    logic [3:0]       digito_d;
    logic [7:0]       anodo_q;
    logic [7:0]       anodo_d;

    // One double-dabble step: add 3 to nibbles >= 5, then shift left
    always_comb begin
        acc_add = acc_q;
        for (int i = 0; i < NDIG; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                acc_add[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        {acc_d, sh_d} = {acc_add, sh_q} << 1;
    end

    // Conversion FSM with registered busy/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            disp_q    <= '0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
        end else begin
            listo_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cargar) begin
                        sh_q      <= bus.valor;
                        acc_q     <= '0;
                        cnt_q     <= CW'(WIDTH);
                        ocupado_q <= 1'b1;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        listo_q <= 1'b1;
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_q    <= acc_q;
                    ocupado_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Next scan slot and its digit/anode pattern, seen through
    // the display value that will hold after this edge
    always_comb begin
        wrap    = (presc_q == PW'(REFRESH_DIV - 1));
        presc_d = wrap ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (wrap)
            idx_d = (idx_q == 3'(NDIG - 1)) ? 3'd0 : idx_q + 3'd1;
        disp_d   = (state_q == COMMIT) ? acc_q : disp_q;
        disp_pad = 32'(disp_d);
        lead     = 3'd0;
        for (int i = 1; i < NDIG; i++) begin
            if (disp_pad[4*i +: 4] != 4'd0)
                lead = 3'(i);
        end
        digito_d = disp_pad[{idx_d, 2'b00} +: 4];
        anodo_d  = 8'hFF;
        if (!(BLANK_LZ && (idx_d > lead)))
            anodo_d[idx_d] = 1'b0;
    end

    // Free-running scanner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= 3'd0;
            digito_q <= 4'd0;
            anodo_q  <= 8'hFE;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            digito_q <= digito_d;
            anodo_q  <= anodo_d;
        end
    end

    assign bus.ocupado = ocupado_q;
    assign bus.listo   = listo_q;
    assign bus.digito  = digito_q;
    assign bus.anodo   = anodo_q;

endmodule

// File: tb/tb_bin_a_bcd_barrido.sv
// tb_bin_a_bcd_barrido: directed checks of conversion, scanning,
// blanking and reset for two instances (blanking on and off).
module tb_bin_a_bcd_barrido;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   ncmp = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   first;
    int   cnt;
    logic busy0;

    bin_a_bcd_barrido_if #(.WIDTH(16)) b1 ();
    bin_a_bcd_barrido_if #(.WIDTH(16)) b2 ();

    bin_a_bcd_barrido #(
        .WIDTH(16), .NDIG(5), .REFRESH_DIV(4), .BLANK_LZ(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );

    bin_a_bcd_barrido #(
        .WIDTH(16), .NDIG(5), .REFRESH_DIV(4), .BLANK_LZ(1'b0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    always #5 clk = ~clk;

    // Cycles since reset release: slot = (cyc/4) % 5
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_slot(input int s);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (((cyc / 4) % 5) == s) found = 1'b1;
        end
        chk("slot_reached", {31'd0, found}, 32'd1);
    endtask

    task automatic slot(input string tag, input int s,
                        input logic [3:0] d, input logic [7:0] a);
        logic [7:0] a2;
        a2 = 8'hFF & ~(8'h01 << s);
        goto_slot(s);
        chk({tag, "_dig"}, b1.digito, d);
        chk({tag, "_an"}, b1.anodo, a);
        chk({tag, "_dig_nb"}, b2.digito, d);
        chk({tag, "_an_nb"}, b2.anodo, a2);
    endtask

    task automatic drive(input logic [15:0] v, input logic c);
        b1.valor  = v;
        b2.valor  = v;
        b1.cargar = c;
        b2.cargar = c;
    endtask

    task automatic run_conv(
        input  logic [15:0] v,
        input  int          pk,
        input  logic [15:0] pv,
        input  int          ck,
        input  logic [15:0] cv,
        input  int          nk,
        output int          f,
        output int          n,
        output logic        busy
    );
        drive(v, 1'b1);
        step();
        drive(v, 1'b0);
        busy = b1.ocupado;
        f = -1;
        n = 0;
        for (int k = 1; k <= nk; k++) begin
            if (k == pk) drive(pv, 1'b1);
            if (k == ck) drive(cv, 1'b0);
            step();
            if (k == pk) drive(pv, 1'b0);
            if (b1.listo) begin
                n++;
                if (f < 0) f = k;
            end
        end
    endtask

    initial begin
        drive(16'd0, 1'b0);

        // Power-up reset
        #2 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_anodo", b1.anodo, 8'hFE);
        chk("rst_digito", b1.digito, 4'd0);
        chk("rst_ocupado", b1.ocupado, 1'b0);
        chk("rst_listo", b1.listo, 1'b0);
        chk("rst_anodo_nb", b2.anodo, 8'hFE);
        rst_n = 1'b1;

        // 12345
        run_conv(16'd12345, -1, 0, -1, 0, 20, first, cnt, busy0);
        chk("c12345_busy", busy0, 1'b1);
        chk("c12345_listo_at", first, 16);
        chk("c12345_listo_cnt", cnt, 1);
        chk("c12345_idle", b1.ocupado, 1'b0);
        slot("s12345_0", 0, 4'd5, 8'hFE);
        slot("s12345_1", 1, 4'd4, 8'hFD);
        slot("s12345_2", 2, 4'd3, 8'hFB);
        slot("s12345_3", 3, 4'd2, 8'hF7);
        slot("s12345_4", 4, 4'd1, 8'hEF);

        // Free-running scan, all digits lit
        for (int i = 0; i < 40; i++) begin
            step();
            chk("scan_anodo", b1.anodo,
                8'hFF & ~(8'h01 << ((cyc / 4) % 5)));
        end

        // Asynchronous reset between edges
        goto_slot(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_anodo", b1.anodo, 8'hFE);
        chk("arst_digito", b1.digito, 4'd0);
        chk("arst_ocupado", b1.ocupado, 1'b0);
        chk("arst_listo", b1.listo, 1'b0);
        step();
        rst_n = 1'b1;

        // 65535
        run_conv(16'd65535, -1, 0, -1, 0, 20, first, cnt, busy0);
        chk("c65535_listo_at", first, 16);
        slot("s65535_0", 0, 4'd5, 8'hFE);
        slot("s65535_1", 1, 4'd3, 8'hFD);
        slot("s65535_2", 2, 4'd5, 8'hFB);
        slot("s65535_3", 3, 4'd5, 8'hF7);
        slot("s65535_4", 4, 4'd6, 8'hEF);

        // 0: only digit 0 lit when blanking
        run_conv(16'd0, -1, 0, -1, 0, 20, first, cnt, busy0);
        chk("c0_listo_cnt", cnt, 1);
        slot("s0_0", 0, 4'd0, 8'hFE);
        slot("s0_1", 1, 4'd0, 8'hFF);
        slot("s0_2", 2, 4'd0, 8'hFF);
        slot("s0_3", 3, 4'd0, 8'hFF);
        slot("s0_4", 4, 4'd0, 8'hFF);

        // 7: blanked vs fully lit instance
        run_conv(16'd7, -1, 0, -1, 0, 20, first, cnt, busy0);
        slot("s7_0", 0, 4'd7, 8'hFE);
        slot("s7_1", 1, 4'd0, 8'hFF);
        slot("s7_2", 2, 4'd0, 8'hFF);
        slot("s7_3", 3, 4'd0, 8'hFF);
        slot("s7_4", 4, 4'd0, 8'hFF);

        // Busy: cargar and valor changes ignored
        run_conv(16'd4321, 5, 16'd9999, 8, 16'd1111, 20,
                 first, cnt, busy0);
        chk("busy_listo_cnt", cnt, 1);
        chk("busy_listo_at", first, 16);
        slot("s4321_0", 0, 4'd1, 8'hFE);
        slot("s4321_1", 1, 4'd2, 8'hFD);
        slot("s4321_2", 2, 4'd3, 8'hFB);
        slot("s4321_3", 3, 4'd4, 8'hF7);
        slot("s4321_4", 4, 4'd0, 8'hFF);

        // Back-to-back: next load sampled at edge 18
        run_conv(16'd4321, -1, 0, -1, 0, 17, first, cnt, busy0);
        chk("b2b_first_at", first, 16);
        run_conv(16'd9999, -1, 0, -1, 0, 20, first, cnt, busy0);
        chk("b2b_accept", busy0, 1'b1);
        chk("b2b_listo_at", first, 16);
        chk("b2b_listo_cnt", cnt, 1);
        slot("s9999_0", 0, 4'd9, 8'hFE);
        slot("s9999_3", 3, 4'd9, 8'hF7);
        slot("s9999_4", 4, 4'd0, 8'hFF);

        // Reset in the middle of a conversion of 500
        drive(16'd500, 1'b1);
        step();
        drive(16'd500, 1'b0);
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ocupado", b1.ocupado, 1'b0);
        chk("mrst_listo", b1.listo, 1'b0);
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (b1.listo) cnt++;
        end
        chk("mrst_no_listo", cnt, 0);
        slot("smrst_0", 0, 4'd0, 8'hFE);
        slot("smrst_1", 1, 4'd0, 8'hFF);
        slot("smrst_2", 2, 4'd0, 8'hFF);

        run_conv(16'd500, -1, 0, -1, 0, 20, first, cnt, busy0);
        chk("c500_listo_at", first, 16);
        slot("s500_0", 0, 4'd0, 8'hFE);
        slot("s500_1", 1, 4'd0, 8'hFD);
        slot("s500_2", 2, 4'd5, 8'hFB);
        slot("s500_3", 3, 4'd0, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end
endmodule
